// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, defaults and lock-FSM state type for the jam cost arbiter
package jam_pkg;
    localparam int JAM_IDX_W     = 3;
    localparam int JAM_COST_W    = 7;
    localparam int JAM_SUM_W     = 10;
    localparam int JAM_NUM_REQ   = 4;
    localparam int JAM_BURST_LEN = 8;
    typedef enum logic {IDLE, BURST} jam_state_t;
endpackage

// File: rtl/jam_rr_picker.sv
// jam_rr_picker: combinational round-robin pick starting the search at ptr
module jam_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id
);
    logic [ID_W-1:0] k;
    // Walk the search order backwards so the earliest requester after ptr wins last
    always_comb begin
        gnt = '0;
        id  = '0;
        k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) begin
                id  = k;
                gnt = NUM_REQ'(1) << k;
            end
        end
    end
endmodule

// File: rtl/jam_cost_arbiter.sv
// jam_cost_arbiter: round-robin, burst-locked sharing of one cost ROM port among engines
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int NUM_REQ   = JAM_NUM_REQ,
    parameter int BURST_LEN = JAM_BURST_LEN,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [JAM_IDX_W*NUM_REQ-1:0]   req_w,
    input  logic [JAM_IDX_W*NUM_REQ-1:0]   req_j,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [JAM_IDX_W-1:0]           W,
    output logic [JAM_IDX_W-1:0]           J,
    input  logic [JAM_COST_W-1:0]          Cost,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [JAM_COST_W-1:0]          rsp_cost,
    output logic                           rsp_last,
    output logic                           busy,
    output logic                           err
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    jam_state_t           state, state_nxt;
    logic [ID_W-1:0]      owner, owner_nxt, rr_ptr, rr_nxt, pick_id, sel_id, s1_id;
    logic [CNT_W-1:0]     beat_cnt, cnt_nxt, cnt_plus;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [JAM_IDX_W-1:0] sel_w, sel_j;
    logic                 accept, sel_last, done, err_set, s1_vld, s1_last;

    jam_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .id  (pick_id)
    );

    assign busy = (state == BURST);

    // Grant the lock owner while bursting, otherwise the round-robin pick; mux its beat fields
    always_comb begin
        sel_id   = (state == BURST) ? owner : pick_id;
        gnt      = (state == BURST) ? NUM_REQ'(1) << owner : pick_gnt;
        accept   = |(req & gnt);
        cnt_plus = (state == BURST) ? beat_cnt + 1'b1 : CNT_W'(1);
        sel_w    = '0;
        sel_j    = '0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_id == ID_W'(k)) begin
                sel_w    = req_w[JAM_IDX_W*k +: JAM_IDX_W];
                sel_j    = req_j[JAM_IDX_W*k +: JAM_IDX_W];
                sel_last = req_last[k];
            end
        end
        done = sel_last || (cnt_plus == CNT_W'(BURST_LEN));
    end

    // Lock FSM: a beat that ends the burst (marked last or hitting the cap) releases and advances rr_ptr
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        err_set   = 1'b0;
        if (accept) begin
            if (done) begin
                state_nxt = IDLE;
                rr_nxt    = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
                cnt_nxt   = '0;
                err_set   = !sel_last;
            end else begin
                state_nxt = BURST;
                owner_nxt = sel_id;
                cnt_nxt   = cnt_plus;
            end
        end
    end

    // Lock FSM state and sticky overrun flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
            err      <= err | err_set;
        end
    end

    // Issue stage drives the ROM address; response stage samples Cost one cycle later
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            W         <= '0;
            J         <= '0;
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            s1_last   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_cost  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            s1_vld    <= accept;
            rsp_valid <= s1_vld;
            if (accept) begin
                W       <= sel_w;
                J       <= sel_j;
                s1_id   <= sel_id;
                s1_last <= sel_last;
            end
            if (s1_vld) begin
                rsp_id   <= s1_id;
                rsp_cost <= Cost;
                rsp_last <= s1_last;
            end
        end
    end
endmodule
